div_seq: RTL
============

# div_seq

Sequential signed 32-bit divider that serves the multi-cycle CPU's `div` instruction. The control unit issues a one-cycle start with operands from the A and B registers. The block answers with a busy/done handshake, quotient and remainder for the LO/HI muxes, and a divide-by-zero flag that the control unit turns into an exception. It uses restoring division at one quotient bit per cycle, with sign correction at the end, following MIPS `div` semantics.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `DivStart` input 1: one-cycle request. Sampled only in IDLE.
- `Dividend` input WIDTH: signed dividend (rs). Sampled with `DivStart`.
- `Divisor` input WIDTH: signed divisor (rt). Sampled with `DivStart`.
- `DivBusy` output 1: high while a request is in progress.
- `DivDone` output 1: one-cycle pulse. Results or the zero flag are valid from this cycle on.
- `DivZero` output 1: divisor was zero for the last accepted request.
- `DivLo` output WIDTH: quotient, goes to LO.
- `DivHi` output WIDTH: remainder, goes to HI.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: WIDTH iterations.
  - FIX: sign correction and result write.
  - DONE: one cycle, `DivDone`=1.
- IDLE, `DivStart`=1, `Divisor`≠0:
  - Latch |Dividend| into the quotient shift register and |Divisor| into the divisor register.
  - Clear the WIDTH+1-bit partial remainder.
  - Record the quotient sign as sign(Dividend) XOR sign(Divisor).
  - Record the remainder sign as sign(Dividend).
  - Clear `DivZero`, load the iteration counter with WIDTH−1, go to RUN.
- IDLE, `DivStart`=1, `Divisor`=0:
  - Set `DivZero`, go to DONE.
  - `DivHi`/`DivLo` keep their previous values.
- RUN, one iteration per cycle:
  - Shift {rem, quot} left by one.
  - Trial = rem − divisor. If trial ≥ 0: rem = trial, quot[0] = 1. Else quot[0] = 0.
  - At counter 0 go to FIX; otherwise decrement the counter.
- FIX:
  - `DivLo` = quotient sign ? −quot : quot.
  - `DivHi` = remainder sign ? −rem : rem.
  - Go to DONE.
- DONE: go to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend; 0 remainder stays 0.
  - Magnitudes are taken as unsigned WIDTH-bit, so |−2^31| = 0x80000000.
  - −2^31 / −1 gives `DivLo`=0x80000000, `DivHi`=0. No overflow flag is produced.
- `DivStart` outside IDLE is ignored. It is not queued.
- `DivHi`/`DivLo` change only in FIX. `DivZero` changes only on request acceptance.
- Reset at any time, including mid-RUN, forces the outputs below and discards any partial result.

## Timing
- Request accepted at edge k.
- Nonzero divisor:
  - RUN covers edges k+1..k+WIDTH.
  - FIX writes results at edge k+WIDTH+1.
  - `DivDone`=1 in the cycle after that edge. Latency is WIDTH+2 cycles (34).
- Zero divisor: `DivDone`=1 and `DivZero`=1 in the cycle right after edge k. Latency is 1 cycle.
- `DivBusy`=1 from after edge k until the state returns to IDLE. It is low during the `DivDone` cycle.
- Back-to-back: a new `DivStart` is accepted in the first IDLE cycle after DONE.
- Reset values:
  - State IDLE.
  - `DivBusy`=0, `DivDone`=0, `DivZero`=0.
  - `DivHi`=0, `DivLo`=0.
  - Internal registers 0.

## Structure
- Shared package `div_pkg` holds:
  - State enum `div_state_t` (IDLE, RUN, FIX, DONE).
  - `DIV_WIDTH`=32.
  - Counter width `DIV_CNT_W`=$clog2(DIV_WIDTH).
- One combinational sub-module, `div_step`. It takes {rem, quot, divisor} and returns the next {rem, quot}, so the iteration can be checked in isolation.
- The top level holds the FSM, counter, sign bits and output registers.

## Test plan
- 7 / 2 → `DivLo`=3, `DivHi`=1. `DivDone` 34 cycles after the start edge; `DivBusy` high for the 33 cycles before it.
- −7 / 2 → `DivLo`=0xFFFFFFFD, `DivHi`=0xFFFFFFFF.
- 7 / −2 → `DivLo`=0xFFFFFFFD, `DivHi`=1.
- 0x80000000 / 0xFFFFFFFF → `DivLo`=0x80000000, `DivHi`=0.
- 5 / 0 after a completed 7 / 2:
  - `DivZero`=1 and `DivDone` in the next cycle.
  - `DivHi`=1 and `DivLo`=3 unchanged.
  - `DivZero` clears on the next accepted nonzero request.
- Start 100 / 7, then:
  - Pulse `DivStart` with 9 / 3 at cycle 10. It is ignored; the result is 14 / 2.
  - Assert `reset` at cycle 20 of a second 100 / 7. All outputs go to 0 immediately and no `DivDone` follows.
  - A new 9 / 3 after reset gives 3 / 0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential signed divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quot} left, then subtract
// the divisor if the result stays non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // One extra bit above the remainder keeps the trial's borrow visible.
  always_comb begin
    shifted = {rem_i, quot_i[WIDTH-1]};
    trial   = shifted - {2'b00, divisor_i};
    if (trial[WIDTH+1]) begin
      rem_o  = shifted[WIDTH:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o  = trial[WIDTH:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed divider for the CPU's div instruction: magnitudes are
// divided one bit per cycle, and the signs are restored in a final FIX cycle.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DivStart,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             DivBusy,
  output logic             DivDone,
  output logic             DivZero,
  output logic [WIDTH-1:0] DivLo,
  output logic [WIDTH-1:0] DivHi
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic             qSign_q, qSign_d;
  logic             rSign_q, rSign_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;

  logic [WIDTH:0]   stepRem;
  logic [WIDTH-1:0] stepQuot;
  logic [WIDTH-1:0] dividendAbs;
  logic [WIDTH-1:0] divisorAbs;

  assign dividendAbs = Dividend[WIDTH-1] ? -Dividend : Dividend;
  assign divisorAbs  = Divisor[WIDTH-1]  ? -Divisor  : Divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quot_i    (quot_q),
    .divisor_i (divisor_q),
    .rem_o     (stepRem),
    .quot_o    (stepQuot)
  );

  // A zero divisor skips the datapath entirely and leaves LO/HI untouched.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    divisor_d = divisor_q;
    qSign_d   = qSign_q;
    rSign_d   = rSign_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    zero_d    = zero_q;
    unique case (state_q)
      IDLE: begin
        if (DivStart) begin
          if (Divisor == '0) begin
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            zero_d    = 1'b0;
            quot_d    = dividendAbs;
            divisor_d = divisorAbs;
            rem_d     = '0;
            qSign_d   = Dividend[WIDTH-1] ^ Divisor[WIDTH-1];
            rSign_d   = Dividend[WIDTH-1];
            cnt_d     = CNT_W'(WIDTH - 1);
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        rem_d  = stepRem;
        quot_d = stepQuot;
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        lo_d    = qSign_q ? -quot_q : quot_q;
        hi_d    = rSign_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      qSign_q   <= 1'b0;
      rSign_q   <= 1'b0;
      lo_q      <= '0;
      hi_q      <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      divisor_q <= divisor_d;
      qSign_q   <= qSign_d;
      rSign_q   <= rSign_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      zero_q    <= zero_d;
    end
  end

  assign DivBusy = (state_q == RUN) || (state_q == FIX);
  assign DivDone = (state_q == DONE);
  assign DivZero = zero_q;
  assign DivLo   = lo_q;
  assign DivHi   = hi_q;

endmodule
